// File: rtl/interrupt_controller.sv
// Latches, masks and prioritises external interrupt requests and sequences the
// ROM's single-level interrupt entry (jump to 240) and return (restore saved PC).
module interrupt_controller #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               global_en,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               jump_enable,
  input  logic               reti,
  output logic               interrupt_jump,
  output logic               interrupt_clear_status,
  output logic [2:0]         irq_id,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] irq_mask,
  output logic               in_service
);

  typedef enum logic [1:0] {IDLE, JUMP, SERVICE, RETURN} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [2:0]         irq_id_q, irq_id_d;
  logic               in_service_q, in_service_d;
  logic               arm_q;

  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [2:0]         winner;
  logic               take;

  // arm_q blocks edge detection for the first cycle after reset, so a source
  // held high through reset needs a fresh rising edge before it can fire.
  assign set_vec = irq_in & ~irq_prev_q & {NUM_IRQ{arm_q}};
  assign req     = pending_q & mask_q;
  assign take    = (state_q == IDLE) && global_en && (|req) && !jump_enable;

  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) winner = 3'(i);
    end
  end

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_vec[i] = take && (winner == 3'(i));
    end
  end

  // A new edge on the bit being cleared wins, so that request is kept.
  always_comb begin
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    mask_d       = mask_we ? mask_wdata : mask_q;
    irq_id_d     = take ? winner : irq_id_q;
    in_service_d = in_service_q;
    if (state_q == JUMP)   in_service_d = 1'b1;
    if (state_q == RETURN) in_service_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
      arm_q        <= 1'b0;
    end else begin
      irq_prev_q   <= irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      irq_id_q     <= irq_id_d;
      in_service_q <= in_service_d;
      arm_q        <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // No nesting: SERVICE only leaves on reti, new requests just stay pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = JUMP;
      JUMP:    state_d = SERVICE;
      SERVICE: if (reti) state_d = RETURN;
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    interrupt_jump         = (state_q == JUMP);
    interrupt_clear_status = (state_q == RETURN);
  end

  assign irq_id      = irq_id_q;
  assign irq_pending = pending_q;
  assign irq_mask    = mask_q;
  assign in_service  = in_service_q;

endmodule
